// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
//
// Fetches one 16-bit instruction at a time from instruction memory. It keeps
// at most one request outstanding and holds the returned word in an
// instruction register (IR) for the decoder. The decoder can stall the IR,
// redirect fetch with a jump, or squash the IR and any in-flight response
// with a flush.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   o_imem_req/o_imem_addr  one-cycle request pulse and its address
//   i_imem_valid/i_imem_data response strobe and word ([15:12] op, [11:0] operand)
//   o_valid                 IR holds a live instruction
//   o_opcode/o_operand      IR fields, driven in every state
//   o_pc                    address of the IR instruction
//   i_stall                 downstream not accepting, so the IR holds
//   i_jump/i_jump_target    redirect fetch (takes priority over i_flush)
//   i_flush                 squash the IR and any in-flight response
//
// Optional feature (macro IFETCH_LINK_EN):
//   When the macro is defined, the unit adds output o_link_pc = o_pc + 1.
//   This is the return address for jump-and-link. It is registered
//   together with o_pc.

module instr_fetch_unit #(
  parameter int unsigned           PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  output logic                o_imem_req,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  input  logic                i_imem_valid,
  input  logic [15:0]         i_imem_data,
  output logic                o_valid,
  output logic [3:0]          o_opcode,
  output logic [11:0]         o_operand,
  output logic [PC_WIDTH-1:0] o_pc,
`ifdef IFETCH_LINK_EN
  output logic [PC_WIDTH-1:0] o_link_pc,
`endif
  input  logic                i_stall,
  input  logic                i_jump,
  input  logic                i_flush,
  input  logic [PC_WIDTH-1:0] i_jump_target
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StFull} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                drop_q, drop_d;
  logic [15:0]         ir_q, ir_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] fetch_pc_inc;

  assign fetch_pc_inc = fetch_pc_q + PC_WIDTH'(1);

`ifdef IFETCH_LINK_EN
  logic [PC_WIDTH-1:0] link_q, link_d;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      ir_q       <= '0;
      pc_q       <= '0;
`ifdef IFETCH_LINK_EN
      link_q     <= RESET_PC + PC_WIDTH'(1);
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
`ifdef IFETCH_LINK_EN
      link_q     <= link_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
`ifdef IFETCH_LINK_EN
    link_d     = link_q;
`endif
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        // A redirect or squash that arrives while the request is issued
        // makes the coming response stale.
        state_d = StWait;
        if (i_jump || i_flush) drop_d = 1'b1;
        if (i_jump) fetch_pc_d = i_jump_target;
      end
      StWait: begin
        if (i_imem_valid) begin
          if (drop_q || i_jump || i_flush) begin
            drop_d  = 1'b0;
            state_d = StReq;
            if (i_jump) fetch_pc_d = i_jump_target;
          end else begin
            ir_d       = i_imem_data;
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_inc;
`ifdef IFETCH_LINK_EN
            link_d     = fetch_pc_inc;
`endif
            state_d    = StFull;
          end
        end else begin
          if (i_jump) begin
            drop_d     = 1'b1;
            fetch_pc_d = i_jump_target;
          end
          if (i_flush) drop_d = 1'b1;
        end
      end
      StFull: begin
        // Jump beats flush beats stall. A flush leaves fetch_pc pointing past
        // the squashed instruction.
        if (i_jump) begin
          fetch_pc_d = i_jump_target;
          state_d    = StReq;
        end else if (i_flush || !i_stall) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_imem_req  = (state_q == StReq);
  assign o_imem_addr = o_imem_req ? fetch_pc_q : '0;
  assign o_valid     = (state_q == StFull);
  assign o_opcode    = ir_q[15:12];
  assign o_operand   = ir_q[11:0];
  assign o_pc        = pc_q;
`ifdef IFETCH_LINK_EN
  assign o_link_pc   = link_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        o_imem_req;
  logic [7:0]  o_imem_addr;
  logic        i_imem_valid = 1'b0;
  logic [15:0] i_imem_data = '0;
  logic        o_valid;
  logic [3:0]  o_opcode;
  logic [11:0] o_operand;
  logic [7:0]  o_pc;
  logic        i_stall = 1'b0;
  logic        i_jump = 1'b0;
  logic        i_flush = 1'b0;
  logic [7:0]  i_jump_target = '0;
`ifdef IFETCH_LINK_EN
  logic [7:0]  o_link_pc;
`endif

  int passed = 0;
  int total  = 0;

  logic [15:0] mem [256];
  int          lat = 1;
  int          cnt = 0;
  logic [7:0]  pend_addr = '0;
  logic [7:0]  req_log [$];

  instr_fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_valid (i_imem_valid),
    .i_imem_data  (i_imem_data),
    .o_valid      (o_valid),
    .o_opcode     (o_opcode),
    .o_operand    (o_operand),
    .o_pc         (o_pc),
`ifdef IFETCH_LINK_EN
    .o_link_pc    (o_link_pc),
`endif
    .i_stall      (i_stall),
    .i_jump       (i_jump),
    .i_flush      (i_flush),
    .i_jump_target(i_jump_target)
  );

  always #5 i_clk = ~i_clk;

  // Memory model: a response comes back `lat` cycles after the request cycle.
  always @(negedge i_clk) begin
    i_imem_valid = 1'b0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        i_imem_valid = 1'b1;
        i_imem_data  = mem[pend_addr];
      end
    end
    if (o_imem_req === 1'b1) begin
      cnt       = lat;
      pend_addr = o_imem_addr;
      req_log.push_back(o_imem_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  // Hold reset for three cycles, then release it. On return the bench is in cycle 1.
  task automatic do_reset();
    i_reset = 1'b1;
    i_stall = 1'b0;
    i_jump  = 1'b0;
    i_flush = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    req_log.delete();
    @(negedge i_clk);
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (o_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    total++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else passed++;
    total++; if (o_imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", o_imem_req); else passed++;
    total++; if (o_imem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", o_imem_addr); else passed++;
    total++; if (o_pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", o_pc); else passed++;
    total++; if ({o_opcode, o_operand} !== 16'h0000) $display("FAIL reset_ir: got %h want 0000", {o_opcode, o_operand}); else passed++;
`ifdef IFETCH_LINK_EN
    total++; if (o_link_pc !== 8'h01) $display("FAIL reset_link: got %h want 01", o_link_pc); else passed++;
`endif
  endtask

  task automatic test_first_fetch();
    lat = 1;
    mem[0] = 16'h1ABC;
    do_reset();
    i_stall = 1'b1;
    total++; if ({o_imem_req, o_imem_addr} !== 9'h100) $display("FAIL first_req_c1: got %b/%h want 1/00", o_imem_req, o_imem_addr); else passed++;
    @(negedge i_clk);
    total++; if ({o_imem_req, o_valid} !== 2'b00) $display("FAIL first_c2: got req/valid %b want 00", {o_imem_req, o_valid}); else passed++;
    @(negedge i_clk);
    total++; if (o_valid !== 1'b1) $display("FAIL first_valid_c3: got %b want 1", o_valid); else passed++;
    total++; if (o_opcode !== 4'h1) $display("FAIL first_opcode: got %h want 1", o_opcode); else passed++;
    total++; if (o_operand !== 12'hABC) $display("FAIL first_operand: got %h want abc", o_operand); else passed++;
    total++; if (o_pc !== 8'h00) $display("FAIL first_pc: got %h want 00", o_pc); else passed++;
  endtask

  task automatic test_straight_line();
    logic [7:0]  pcs [$];
    logic [11:0] ops [$];
    lat = 1;
    for (int n = 0; n < 4; n++) mem[n] = 16'(n);
    do_reset();
    for (int c = 0; c < 30 && pcs.size() < 4; c++) begin
      if (o_valid === 1'b1) begin
        pcs.push_back(o_pc);
        ops.push_back(o_operand);
      end
      @(negedge i_clk);
    end
    total++;
    if (pcs.size() != 4) $display("FAIL straight_count: got %0d want 4", pcs.size());
    else begin
      passed++;
      for (int n = 0; n < 4; n++) begin
        total++; if (pcs[n] !== 8'(n)) $display("FAIL straight_pc%0d: got %h want %h", n, pcs[n], 8'(n)); else passed++;
        total++; if (ops[n] !== 12'(n)) $display("FAIL straight_op%0d: got %h want %h", n, ops[n], 12'(n)); else passed++;
        total++; if (req_log[n] !== 8'(n)) $display("FAIL straight_addr%0d: got %h want %h", n, req_log[n], 8'(n)); else passed++;
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    lat = 1;
    mem[0] = 16'h5123;
    do_reset();
    i_stall = 1'b1;
    wait_valid(10, ok);
    total++; if (!ok) $display("FAIL stall_wait: got no valid want valid"); else passed++;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      total++;
      if ({o_valid, o_imem_req, o_pc, o_opcode, o_operand} !== {2'b10, 8'h00, 16'h5123})
        $display("FAIL stall_hold%0d: got v=%b req=%b pc=%h ir=%h want v=1 req=0 pc=00 ir=5123",
                 c, o_valid, o_imem_req, o_pc, {o_opcode, o_operand});
      else passed++;
    end
    i_stall = 1'b0;
    @(negedge i_clk);
    total++; if ({o_imem_req, o_imem_addr} !== 9'h101) $display("FAIL stall_release: got %b/%h want 1/01", o_imem_req, o_imem_addr); else passed++;
  endtask

  task automatic test_jump_in_wait();
    bit ok;
    lat = 2;
    mem[8'h40] = 16'h7040;
    do_reset();
    @(negedge i_clk);  // cycle 2, waiting on address 0
    i_jump = 1'b1;
    i_jump_target = 8'h40;
    @(negedge i_clk);  // stale response arrives this cycle
    i_jump = 1'b0;
    total++; if (o_valid !== 1'b0) $display("FAIL jump_wait_v3: got %b want 0", o_valid); else passed++;
    @(negedge i_clk);
    total++; if (o_valid !== 1'b0) $display("FAIL jump_wait_v4: got %b want 0", o_valid); else passed++;
    total++; if ({o_imem_req, o_imem_addr} !== 9'h140) $display("FAIL jump_wait_req: got %b/%h want 1/40", o_imem_req, o_imem_addr); else passed++;
    wait_valid(10, ok);
    total++; if (!ok) $display("FAIL jump_wait_valid: got no valid want valid"); else passed++;
    total++; if (o_pc !== 8'h40) $display("FAIL jump_wait_pc: got %h want 40", o_pc); else passed++;
    total++; if ({o_opcode, o_operand} !== 16'h7040) $display("FAIL jump_wait_ir: got %h want 7040", {o_opcode, o_operand}); else passed++;
    lat = 1;
  endtask

  task automatic test_flush_full();
    bit ok;
    lat = 1;
    mem[5] = 16'h2005;
    mem[6] = 16'h3006;
    do_reset();
    i_stall = 1'b1;
    wait_valid(10, ok);
    i_jump = 1'b1;
    i_jump_target = 8'h05;
    @(negedge i_clk);
    i_jump = 1'b0;
    wait_valid(10, ok);
    total++; if (!ok || o_pc !== 8'h05) $display("FAIL flush_setup_pc: got %h want 05", o_pc); else passed++;
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    total++; if (o_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", o_valid); else passed++;
    total++; if ({o_imem_req, o_imem_addr} !== 9'h106) $display("FAIL flush_req: got %b/%h want 1/06", o_imem_req, o_imem_addr); else passed++;
    wait_valid(10, ok);
    total++; if (!ok || o_pc !== 8'h06) $display("FAIL flush_next_pc: got %h want 06", o_pc); else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] pcs [$];
    logic [7:0] links [$];
    lat = 1;
    mem[8'hFF] = 16'hF0FF;
    mem[0] = 16'h1ABC;
    do_reset();
    i_stall = 1'b1;
    wait_valid(10, ok);
    // Jump and flush together must act as a jump.
    i_jump = 1'b1;
    i_flush = 1'b1;
    i_jump_target = 8'hFF;
    @(negedge i_clk);
    i_jump = 1'b0;
    i_flush = 1'b0;
    i_stall = 1'b0;
    total++; if ({o_imem_req, o_imem_addr} !== 9'h1FF) $display("FAIL wrap_jump_req: got %b/%h want 1/ff", o_imem_req, o_imem_addr); else passed++;
    for (int c = 0; c < 20 && pcs.size() < 2; c++) begin
      if (o_valid === 1'b1) begin
        pcs.push_back(o_pc);
`ifdef IFETCH_LINK_EN
        links.push_back(o_link_pc);
`else
        links.push_back(o_pc + 8'h01);
`endif
      end
      @(negedge i_clk);
    end
    total++;
    if (pcs.size() != 2) $display("FAIL wrap_count: got %0d want 2", pcs.size());
    else begin
      passed++;
      total++; if (pcs[0] !== 8'hFF) $display("FAIL wrap_pc0: got %h want ff", pcs[0]); else passed++;
      total++; if (pcs[1] !== 8'h00) $display("FAIL wrap_pc1: got %h want 00", pcs[1]); else passed++;
`ifdef IFETCH_LINK_EN
      total++; if (links[0] !== 8'h00) $display("FAIL wrap_link0: got %h want 00", links[0]); else passed++;
      total++; if (links[1] !== 8'h01) $display("FAIL wrap_link1: got %h want 01", links[1]); else passed++;
`endif
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    test_reset();
    test_first_fetch();
    test_straight_line();
    test_stall();
    test_jump_in_wait();
    test_flush_full();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
